pc_fetch_unit: RTL and testbench
================================

# pc_fetch_unit

Fetch-stage program counter and IF/ID pipeline register for the five-stage MIPS core; it consumes the ID-stage comparator's `CMP_result` and redirects fetch for branches, jumps, exceptions/interrupts and `eret`. It owns the architectural fetch PC, tracks delay-slot status for CP0's BD bit, and flags fetch address errors (AdEL) forward to ID.

## Interface
- `RESET_PC`, 32'h0000_3000, PC value after reset
- `HANDLER_PC`, 32'h0000_4180, exception/interrupt entry
- `IM_LO`, 32'h0000_3000, lowest legal fetch address
- `IM_HI`, 32'h0000_6FFC, highest legal fetch address
- `clk` in 1 system clock, rising edge
- `reset` in 1 asynchronous, active-low reset
- `stall` in 1 hazard-unit freeze of PC and IF/ID
- `IF_instr` in 32 instruction word from IM at address `PC`
- `branch` in 1 ID instruction is a conditional branch
- `CMP_result` in 1 comparator outcome for the ID branch
- `imm16` in 16 ID branch offset
- `jump` in 1 ID instruction is j/jal
- `instr_index` in 26 ID jump target field
- `jump_reg` in 1 ID instruction is jr/jalr
- `rs_data` in 32 forwarded rs value for jr/jalr
- `exc_req` in 1 CP0 requests exception/interrupt entry this cycle
- `eret` in 1 eret committing this cycle
- `epc` in 32 CP0 EPC
- `PC` out 32 current fetch address
- `ID_instr` out 32 instruction in ID
- `ID_pc` out 32 address of instruction in ID
- `ID_bd` out 1 ID instruction is in a delay slot
- `ID_exc_adel` out 1 ID instruction had a fetch address error
- `taken` out 1 combinational: control transfer resolved taken in ID

## Operation
- `taken = (branch & CMP_result) | jump | jump_reg`.
- Targets (32-bit, modulo 2^32): branch `ID_pc + 4 + (sext(imm16) << 2)`; jump `{(ID_pc+4)[31:28], instr_index, 2'b00}`; jr `rs_data`.
- Fetch error `adel = (PC[1:0] != 0) | (PC < IM_LO) | (PC > IM_HI)`.
- Next-PC priority, one only per edge:
  1. `exc_req` -> `PC <= HANDLER_PC`; IF/ID loaded with bubble (instr 0, pc `PC`, bd 0, adel 0). Overrides `stall`.
  2. `eret` -> `PC <= epc`; IF/ID bubble as above. Overrides `stall`.
  3. `stall` -> PC and all IF/ID registers hold.
  4. `taken` -> `PC <= target`; IF/ID loads delay slot.
  5. else `PC <= PC + 4` (wraps 32'hFFFF_FFFC -> 0); IF/ID loads.
- IF/ID load: `ID_instr <= adel ? 0 : IF_instr`; `ID_pc <= PC`; `ID_exc_adel <= adel`; `ID_bd <= branch | jump | jump_reg` (value of current ID instruction).
- Delay slot always executes; no annul of slot on taken or not-taken.
- Misaligned jr target is loaded into PC unchanged; error is raised by `adel` at fetch.

## Timing
- Reset (async, `reset`=0): `PC=RESET_PC`, `ID_instr=0`, `ID_pc=0`, `ID_bd=0`, `ID_exc_adel=0`; release synchronous-safe, first fetch at `RESET_PC`.
- Reset asserted mid-operation clears immediately, independent of `clk`; pending redirects lost.
- Branch/jump in ID at cycle n -> `PC = target` at n+1; delay slot enters ID at n+1; target instruction in ID at n+2.
- `exc_req`/`eret` at cycle n -> `PC` = handler/`epc` at n+1, `ID_instr=0` at n+1.
- `taken` and `stall` same cycle: stall wins; branch re-evaluated next cycle with fresh `CMP_result`.
- `exc_req` and `eret` same cycle: `exc_req` wins.
- `taken`, `adel` purely combinational; all other outputs registered.

## Test plan
- Reset then 3 unstalled cycles -> `PC` 0x3000, 0x3004, 0x3008, 0x300C; `ID_pc` trails by one cycle.
- beq at `ID_pc`=0x3008, `imm16`=16'hFFFE, `CMP_result`=1 -> next `PC`=0x3004, delay slot 0x300C in ID with `ID_bd`=1; `CMP_result`=0 -> `PC`=0x3010.
- jr with `rs_data`=0x3001 -> `PC`=0x3001, next cycle `ID_exc_adel`=1, `ID_instr`=0.
- `stall`=1 with `taken`=1 for 2 cycles -> PC/IF/ID hold; on release target loaded.
- `exc_req` with `stall`=1 at PC=0x3040 -> `PC`=0x4180, `ID_instr`=0; later `eret` with `epc`=0x3044 -> `PC`=0x3044.
- Assert `reset` low between clock edges while PC=0x3100 -> `PC`=0x3000 immediately, all ID outputs 0.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// Fetch-stage PC and IF/ID register for the five-stage MIPS core.
// Redirects on branch/jump/jr in ID, exception entry and eret.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
  parameter logic [31:0] IM_LO      = 32'h0000_3000,
  parameter logic [31:0] IM_HI      = 32'h0000_6FFC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [31:0] IF_instr,
  input  logic        branch,
  input  logic        CMP_result,
  input  logic [15:0] imm16,
  input  logic        jump,
  input  logic [25:0] instr_index,
  input  logic        jump_reg,
  input  logic [31:0] rs_data,
  input  logic        exc_req,
  input  logic        eret,
  input  logic [31:0] epc,
  output logic [31:0] PC,
  output logic [31:0] ID_instr,
  output logic [31:0] ID_pc,
  output logic        ID_bd,
  output logic        ID_exc_adel,
  output logic        taken
);

  logic [31:0] r_pc;
  logic [31:0] r_id_instr;
  logic [31:0] r_id_pc;
  logic        r_id_bd;
  logic        r_id_adel;

  logic        w_adel;
  logic        w_ctl;
  logic [31:0] w_pc4;
  logic [31:0] w_id_pc4;
  logic [31:0] w_imm_ext;
  logic [31:0] w_br_tgt;
  logic [31:0] w_j_tgt;
  logic [31:0] w_target;
  logic [31:0] w_next_pc;

  assign w_adel = (r_pc[1:0] != 2'b00)
                | (r_pc < IM_LO)
                | (r_pc > IM_HI);

  assign taken = (branch & CMP_result)
               | jump | jump_reg;
  assign w_ctl = branch | jump | jump_reg;

  assign w_pc4     = r_pc + 32'd4;
  assign w_id_pc4  = r_id_pc + 32'd4;
  assign w_imm_ext = {{14{imm16[15]}}, imm16, 2'b00};
  assign w_br_tgt  = w_id_pc4 + w_imm_ext;
  assign w_j_tgt   = {w_id_pc4[31:28], instr_index, 2'b00};

  always_comb begin
    w_target = w_br_tgt;
    if (jump_reg)  w_target = rs_data;
    else if (jump) w_target = w_j_tgt;
  end

  assign w_next_pc = taken ? w_target : w_pc4;

  // exc_req/eret flush IF/ID with a bubble and override stall
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc       <= RESET_PC;
      r_id_instr <= 32'd0;
      r_id_pc    <= 32'd0;
      r_id_bd    <= 1'b0;
      r_id_adel  <= 1'b0;
    end else if (exc_req || eret) begin
      r_pc       <= exc_req ? HANDLER_PC : epc;
      r_id_instr <= 32'd0;
      r_id_pc    <= r_pc;
      r_id_bd    <= 1'b0;
      r_id_adel  <= 1'b0;
    end else if (!stall) begin
      r_pc       <= w_next_pc;
      r_id_instr <= w_adel ? 32'd0 : IF_instr;
      r_id_pc    <= r_pc;
      r_id_bd    <= w_ctl;
      r_id_adel  <= w_adel;
    end
  end

  assign PC          = r_pc;
  assign ID_instr    = r_id_instr;
  assign ID_pc       = r_id_pc;
  assign ID_bd       = r_id_bd;
  assign ID_exc_adel = r_id_adel;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed test-plan steps plus
// random traffic checked against an arithmetic reference model.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic [31:0] IF_instr;
  logic        branch;
  logic        CMP_result;
  logic [15:0] imm16;
  logic        jump;
  logic [25:0] instr_index;
  logic        jump_reg;
  logic [31:0] rs_data;
  logic        exc_req;
  logic        eret;
  logic [31:0] epc;
  logic [31:0] PC;
  logic [31:0] ID_instr;
  logic [31:0] ID_pc;
  logic        ID_bd;
  logic        ID_exc_adel;
  logic        taken;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] m_pc, m_instr, m_idpc;
  logic        m_bd, m_adel;

  always #5 clk = ~clk;

  pc_fetch_unit dut (
    .clk(clk), .reset(reset), .stall(stall),
    .IF_instr(IF_instr), .branch(branch),
    .CMP_result(CMP_result), .imm16(imm16),
    .jump(jump), .instr_index(instr_index),
    .jump_reg(jump_reg), .rs_data(rs_data),
    .exc_req(exc_req), .eret(eret), .epc(epc),
    .PC(PC), .ID_instr(ID_instr), .ID_pc(ID_pc),
    .ID_bd(ID_bd), .ID_exc_adel(ID_exc_adel),
    .taken(taken)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_pc = 32'h3000; m_instr = 0; m_idpc = 0;
    m_bd = 0; m_adel = 0;
  endtask

  task automatic chk_state(input string tag);
    chk({tag, ".PC"}, PC, m_pc);
    chk({tag, ".ID_instr"}, ID_instr, m_instr);
    chk({tag, ".ID_pc"}, ID_pc, m_idpc);
    chk({tag, ".ID_bd"}, {31'd0, ID_bd}, {31'd0, m_bd});
    chk({tag, ".ID_adel"}, {31'd0, ID_exc_adel},
        {31'd0, m_adel});
  endtask

  task automatic idle();
    stall = 0; branch = 0; CMP_result = 0; jump = 0;
    jump_reg = 0; exc_req = 0; eret = 0;
  endtask

  // one clock: check taken, predict, clock, compare
  task automatic cyc(input string tag);
    bit          bad_fetch, tk;
    logic [31:0] tgt, seq, off;
    #1;
    bad_fetch = (m_pc % 4 != 0) || (m_pc < 32'h3000)
             || (m_pc > 32'h6FFC);
    tk = (branch && CMP_result) || jump || jump_reg;
    chk({tag, ".taken"}, {31'd0, taken}, {31'd0, tk});
    seq = m_idpc + 4;
    off = 32'(signed'(imm16)) * 4;
    if (jump_reg)  tgt = rs_data;
    else if (jump) tgt = (seq & 32'hF000_0000)
                        | (32'(instr_index) * 4);
    else           tgt = seq + off;
    @(posedge clk);
    #1;
    if (exc_req || eret) begin
      m_idpc = m_pc; m_instr = 0; m_bd = 0; m_adel = 0;
      m_pc = exc_req ? 32'h4180 : epc;
    end else if (!stall) begin
      m_idpc  = m_pc;
      m_instr = bad_fetch ? 0 : IF_instr;
      m_adel  = bad_fetch;
      m_bd    = branch || jump || jump_reg;
      m_pc    = tk ? tgt : m_pc + 4;
    end
    chk_state(tag);
  endtask

  initial begin
    logic [31:0] held;
    reset = 0; idle();
    IF_instr = 32'h1111_0000; imm16 = 0;
    instr_index = 0; rs_data = 0; epc = 0;
    m_reset();
    #12;
    chk_state("reset");
    reset = 1;

    // sequential fetch
    for (int i = 0; i < 3; i++) begin
      IF_instr = 32'h1111_0000 + i;
      cyc("seq");
    end
    chk("seq3.PC", PC, 32'h300C);
    chk("seq3.ID_pc", ID_pc, 32'h3008);

    // beq taken backwards
    branch = 1; CMP_result = 1; imm16 = 16'hFFFE;
    IF_instr = 32'hAAAA_0001;
    cyc("beq_t");
    chk("beq_t.PC", PC, 32'h3004);
    chk("beq_t.slot", ID_pc, 32'h300C);
    chk("beq_t.bd", {31'd0, ID_bd}, 32'd1);
    idle(); cyc("beq_t2");

    // beq not taken: sequential
    branch = 1; CMP_result = 0;
    cyc("beq_n");
    idle();

    // jr to misaligned address
    jump_reg = 1; rs_data = 32'h3001;
    cyc("jr_mis");
    chk("jr_mis.PC", PC, 32'h3001);
    idle(); IF_instr = 32'hDEAD_BEEF;
    cyc("jr_mis2");
    chk("jr_mis2.adel", {31'd0, ID_exc_adel}, 32'd1);
    chk("jr_mis2.instr", ID_instr, 32'd0);

    // stall beats taken for 2 cycles
    jump = 1; instr_index = 26'h0000C40;
    stall = 1;
    held = PC;
    cyc("stall1"); cyc("stall2");
    chk("stall.hold", PC, held);
    stall = 0;
    cyc("stall_rel");
    chk("stall_rel.PC", PC, 32'h3100);
    idle();

    // exception with stall at 0x3040, then eret
    jump_reg = 1; rs_data = 32'h3040;
    cyc("to3040");
    idle();
    exc_req = 1; stall = 1;
    cyc("exc");
    chk("exc.PC", PC, 32'h4180);
    idle(); cyc("hnd");
    exc_req = 1; eret = 1; epc = 32'h3044;
    cyc("exc_eret");
    idle(); eret = 1;
    cyc("eret");
    chk("eret.PC", PC, 32'h3044);
    idle();

    // async reset between edges at 0x3100
    jump_reg = 1; rs_data = 32'h3100;
    cyc("to3100");
    idle(); stall = 1; cyc("hold3100");
    chk("pre_rst.PC", PC, 32'h3100);
    @(negedge clk);
    reset = 0; m_reset();
    #1;
    chk_state("async_rst");
    @(negedge clk);
    reset = 1; idle();
    #1;
    chk_state("rst_rel");

    // random traffic
    for (int i = 0; i < 400; i++) begin
      int k;
      idle();
      IF_instr    = $urandom;
      CMP_result  = 1'($urandom);
      imm16       = 16'($urandom);
      instr_index = 26'($urandom_range(32'hC00, 32'h1BFF));
      rs_data     = ($urandom_range(0, 7) == 0)
                  ? $urandom
                  : $urandom_range(32'h3000, 32'h6FFC) & ~32'h3;
      epc         = $urandom_range(32'h3000, 32'h6FFC) & ~32'h3;
      stall       = ($urandom_range(0, 5) == 0);
      k = $urandom_range(0, 19);
      if (k < 4)       branch = 1;
      else if (k == 4) jump = 1;
      else if (k == 5) jump_reg = 1;
      else if (k == 6) exc_req = 1;
      else if (k == 7) eret = 1;
      else if (k == 8) begin exc_req = 1; eret = 1; end
      cyc("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
